// File: rtl/dual_down_counter_pkg.sv
// Shared definitions for the dual-channel down-counter timer.
// No logic here; only types and defaults.
// No flow control.
package dual_down_counter_pkg;

    // Default counter/preset width per channel.
    localparam int WIDTH_DEF = 64;

    // Per-channel FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dual_down_counter_if.sv
// Control and readback bundle between a timer client and the dual down-counter.
// No storage; the wires are passed straight through.
// No flow control: commands are level-sampled every clock.
interface dual_down_counter_if
    import dual_down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             Slt;
    logic             En;
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic             AutoReload;
    logic [WIDTH-1:0] Output0;
    logic [WIDTH-1:0] Output1;
    logic             Zero0;
    logic             Zero1;
    logic             Busy0;
    logic             Busy1;

    // Client side: issues commands, reads counts and flags.
    modport master (
        output Slt, En, Load, LoadValue, AutoReload,
        input  Output0, Output1, Zero0, Zero1, Busy0, Busy1
    );

    // Timer side: consumes commands, drives counts and flags.
    modport slave (
        input  Slt, En, Load, LoadValue, AutoReload,
        output Output0, Output1, Zero0, Zero1, Busy0, Busy1
    );
endinterface

// File: rtl/dual_down_counter_channel.sv
// One programmable down-counter channel: load, count to zero, one-shot or auto-reload.
// Latency: every effect is visible one cycle after the causing edge.
// No backpressure: Load/En are only honoured while Sel is high.
module down_counter_channel
    import dual_down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Sel,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Count,
    output logic             Zero,
    output logic             Busy
);

    state_t           state;
    logic [WIDTH-1:0] preset;
    logic             mode;

    logic load_sel;
    logic dec_sel;
    logic count_is_zero;
    logic count_is_one;

    // Commands only reach this channel when it is selected.
    assign load_sel      = Sel & Load;
    assign dec_sel       = Sel & En;
    assign count_is_zero = (Count == '0);
    assign count_is_one  = (Count == WIDTH'(1));

    // Channel FSM with registered count, zero pulse and busy flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_IDLE;
            Count  <= '0;
            preset <= '0;
            mode   <= 1'b0;
            Zero   <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            // Zero is a single-cycle pulse unless re-asserted below.
            Zero <= 1'b0;
            if (load_sel) begin
                // A load wins over decrement and over reload, in any state.
                Count  <= LoadValue;
                preset <= LoadValue;
                mode   <= AutoReload;
                state  <= ST_COUNT;
                Busy   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        Busy <= 1'b0;
                    end
                    ST_COUNT: begin
                        if (count_is_zero) begin
                            // Loaded with zero: finish without decrementing, even if
                            // unselected, so the counter never wraps to all-ones.
                            state <= ST_DONE;
                            Zero  <= 1'b1;
                            Busy  <= 1'b0;
                        end else if (dec_sel) begin
                            Count <= Count - WIDTH'(1);
                            if (count_is_one) begin
                                state <= ST_DONE;
                                Zero  <= 1'b1;
                                Busy  <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (mode) begin
                            // Auto-reload after one dead cycle in DONE.
                            Count <= preset;
                            state <= ST_COUNT;
                            Busy  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/dual_down_counter.sv
// Dual-channel down-counter timer; Slt steers Load/En to channel 0 or 1.
// Latency: one cycle from command edge to updated count/flags.
// No backpressure: commands to the unselected channel are ignored.
module dual_down_counter
    import dual_down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    dual_down_counter_if.slave  bus
);

    logic sel0;
    logic sel1;

    // Decode the channel select once; shared inputs fan out unchanged.
    assign sel0 = ~bus.Slt;
    assign sel1 =  bus.Slt;

    down_counter_channel #(.WIDTH(WIDTH)) u_ch0 (
        .Clk        (Clk),
        .Reset      (Reset),
        .Sel        (sel0),
        .En         (bus.En),
        .Load       (bus.Load),
        .LoadValue  (bus.LoadValue),
        .AutoReload (bus.AutoReload),
        .Count      (bus.Output0),
        .Zero       (bus.Zero0),
        .Busy       (bus.Busy0)
    );

    down_counter_channel #(.WIDTH(WIDTH)) u_ch1 (
        .Clk        (Clk),
        .Reset      (Reset),
        .Sel        (sel1),
        .En         (bus.En),
        .Load       (bus.Load),
        .LoadValue  (bus.LoadValue),
        .AutoReload (bus.AutoReload),
        .Count      (bus.Output1),
        .Zero       (bus.Zero1),
        .Busy       (bus.Busy1)
    );

endmodule

// File: tb/tb_dual_down_counter.sv
module tb_dual_down_counter;
    import dual_down_counter_pkg::*;

    localparam int W = 64;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    dual_down_counter_if #(.WIDTH(W)) bus ();

    dual_down_counter #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [W-1:0] exp1;
        logic [W-1:0] seq1 [10];
        checks = 0;
        errors = 0;

        // 1. Reset held two cycles while Load/En are active.
        Reset          = 1'b1;
        bus.Slt        = 1'b0;
        bus.En         = 1'b1;
        bus.Load       = 1'b1;
        bus.LoadValue  = 64'd9;
        bus.AutoReload = 1'b1;
        tick();
        tick();
        chk("rst_out0",  bus.Output0, 64'd0);
        chk("rst_out1",  bus.Output1, 64'd0);
        chk("rst_zero0", 64'(bus.Zero0), 64'd0);
        chk("rst_zero1", 64'(bus.Zero1), 64'd0);
        chk("rst_busy0", 64'(bus.Busy0), 64'd0);
        chk("rst_busy1", 64'(bus.Busy1), 64'd0);

        // 2. Channel 0 one-shot from 5 (En also high on the load edge).
        Reset          = 1'b0;
        bus.Slt        = 1'b0;
        bus.Load       = 1'b1;
        bus.LoadValue  = 64'd5;
        bus.AutoReload = 1'b0;
        bus.En         = 1'b1;
        tick();
        chk("os_load_out0", bus.Output0, 64'd5);
        chk("os_load_busy0", 64'(bus.Busy0), 64'd1);
        bus.Load = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("os_out0",  bus.Output0, 64'(5 - i));
            chk("os_zero0", 64'(bus.Zero0), (i == 5) ? 64'd1 : 64'd0);
            chk("os_out1",  bus.Output1, 64'd0);
        end
        chk("os_busy0_done", 64'(bus.Busy0), 64'd0);
        tick();
        chk("os_hold_out0",  bus.Output0, 64'd0);
        chk("os_hold_zero0", 64'(bus.Zero0), 64'd0);

        // 3. Channel 1 auto-reload from 3: 3,2,1,0,3,2,1,0,3,2,1.
        bus.Slt        = 1'b1;
        bus.Load       = 1'b1;
        bus.LoadValue  = 64'd3;
        bus.AutoReload = 1'b1;
        tick();
        chk("ar_load_out1", bus.Output1, 64'd3);
        bus.Load = 1'b0;
        seq1 = '{64'd2, 64'd1, 64'd0, 64'd3, 64'd2, 64'd1, 64'd0, 64'd3, 64'd2, 64'd1};
        for (int i = 0; i < 10; i++) begin
            tick();
            exp1 = seq1[i];
            chk("ar_out1",  bus.Output1, exp1);
            chk("ar_zero1", 64'(bus.Zero1), (exp1 == 64'd0) ? 64'd1 : 64'd0);
            chk("ar_busy1", 64'(bus.Busy1), (exp1 == 64'd0) ? 64'd0 : 64'd1);
            chk("ar_out0",  bus.Output0, 64'd0);
        end

        // 4. Load beats En in the same cycle on channel 0; channel 1 (unselected) holds 1.
        bus.Slt        = 1'b0;
        bus.Load       = 1'b1;
        bus.LoadValue  = 64'd7;
        bus.AutoReload = 1'b0;
        bus.En         = 1'b0;
        tick();
        chk("lw_out0_7", bus.Output0, 64'd7);
        bus.LoadValue = 64'd10;
        bus.En        = 1'b1;
        tick();
        chk("lw_out0_10", bus.Output0, 64'd10);
        chk("lw_out1_hold", bus.Output1, 64'd1);
        bus.Load = 1'b0;
        tick();
        chk("lw_out0_9", bus.Output0, 64'd9);

        // 5. Load zero one-shot: zero pulse next cycle, no wrap.
        bus.Load      = 1'b1;
        bus.LoadValue = 64'd0;
        bus.En        = 1'b0;
        tick();
        chk("z_load_out0",  bus.Output0, 64'd0);
        chk("z_load_busy0", 64'(bus.Busy0), 64'd1);
        chk("z_load_zero0", 64'(bus.Zero0), 64'd0);
        bus.Load = 1'b0;
        tick();
        chk("z_pulse_zero0", 64'(bus.Zero0), 64'd1);
        chk("z_pulse_out0",  bus.Output0, 64'd0);
        chk("z_pulse_busy0", 64'(bus.Busy0), 64'd0);
        bus.En = 1'b1;
        tick();
        chk("z_nowrap_out0", bus.Output0, 64'd0);
        chk("z_after_zero0", 64'(bus.Zero0), 64'd0);

        // Loaded-zero channel 1 finishes even after selection moves away.
        bus.Slt       = 1'b1;
        bus.Load      = 1'b1;
        bus.LoadValue = 64'd0;
        bus.En        = 1'b0;
        tick();
        chk("uz_busy1", 64'(bus.Busy1), 64'd1);
        bus.Slt  = 1'b0;
        bus.Load = 1'b0;
        tick();
        chk("uz_zero1", 64'(bus.Zero1), 64'd1);
        chk("uz_out1",  bus.Output1, 64'd0);

        // 6. Reset mid-count on channel 1, then En alone must not move it.
        bus.Slt        = 1'b1;
        bus.Load       = 1'b1;
        bus.LoadValue  = 64'd4;
        bus.AutoReload = 1'b0;
        tick();
        chk("mr_load_out1", bus.Output1, 64'd4);
        bus.Load = 1'b0;
        bus.En   = 1'b1;
        tick();
        tick();
        chk("mr_out1_2", bus.Output1, 64'd2);
        Reset = 1'b1;
        tick();
        chk("mr_rst_out1",  bus.Output1, 64'd0);
        chk("mr_rst_busy1", 64'(bus.Busy1), 64'd0);
        Reset = 1'b0;
        tick();
        tick();
        chk("mr_hold_out1",  bus.Output1, 64'd0);
        chk("mr_hold_busy1", 64'(bus.Busy1), 64'd0);
        chk("mr_hold_zero1", 64'(bus.Zero1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
